// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CHK    = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_e;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = $clog2(BYTES_PER_WORD);
  localparam int DEFAULT_DEPTH  = 1024;
  localparam int DEFAULT_ADDR_W = 10;

  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Collects accepted stream bytes into little-endian 32-bit words and
// emits a one-cycle word_valid pulse together with the completed word.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic        last_lane_o,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [31:0]       shift_q, shift_d;
  logic [31:0]       word_q, word_d;
  logic              valid_q, valid_d;

  // Next-state for lane counter, shift register and word output.
  always_comb begin
    lane_d  = lane_q;
    shift_d = shift_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (clr_i) begin
      lane_d = '0;
    end else if (byte_en_i) begin
      // Bytes enter at the top, so the first byte ends up in bits [7:0].
      shift_d = {byte_i, shift_q[31:8]};
      lane_d  = lane_q + LANE_W'(1);
      if (lane_q == LANE_W'(BYTES_PER_WORD - 1)) begin
        word_d  = {byte_i, shift_q[31:8]};
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end else begin
      lane_d = lane_q;
    end
  end

  // Packer state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lane_q  <= '0;
      shift_q <= 32'd0;
      word_q  <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      lane_q  <= lane_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign last_lane_o  = (lane_q == LANE_W'(BYTES_PER_WORD - 1));
  assign word_valid_o = valid_q;
  assign word_o       = word_q;

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: length-framed byte stream to word writes.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              core_rst,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [16:0]       word_cnt_q, word_cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              ready_q, ready_d;
  logic              core_rst_q, core_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              accept_s, go_s, clr_s, word_done_s, last_word_s, last_lane_s;
  logic [16:0]       n_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  assign go_s        = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
  assign clr_s       = rst || (state_q == S_IDLE) || go_s;
  assign accept_s    = byte_valid && ready_q;
  assign word_done_s = accept_s && (state_q == S_DATA) && last_lane_s;
  assign last_word_s = ((word_cnt_q + 17'd1) == {1'b0, len_q});
  assign n_s         = {1'b0, byte_data, len_q[7:0]};

  byte_packer u_packer (
    .clk_i        (clk),
    .rst_i        (rst),
    .clr_i        (clr_s),
    .byte_en_i    (accept_s && (state_q == S_DATA)),
    .byte_i       (byte_data),
    .last_lane_o  (last_lane_s),
    .word_valid_o (wr_en),
    .word_o       (wr_data)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_LEN_LO; else state_d = S_IDLE;
      S_LEN_LO: if (accept_s) state_d = S_LEN_HI; else state_d = S_LEN_LO;
      S_LEN_HI: begin
        if (!accept_s)                  state_d = S_LEN_HI;
`ifdef IMEM_LOADER_CHECKSUM_EN
        else if (n_s == 17'd0)          state_d = S_CHK;
`else
        else if (n_s == 17'd0)          state_d = S_DONE;
`endif
        else if (n_s > 17'(DEPTH))      state_d = S_ERR;
        else                            state_d = S_DATA;
      end
      S_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (word_done_s && last_word_s) state_d = S_CHK;
`else
        if (word_done_s && last_word_s) state_d = S_DONE;
`endif
        else                            state_d = S_DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (!accept_s)                  state_d = S_CHK;
        else if (byte_data == csum_q)   state_d = S_DONE;
        else                            state_d = S_ERR;
      end
`else
      S_CHK:    state_d = S_IDLE;
`endif
      S_DONE:   if (start) state_d = S_LEN_LO; else state_d = S_DONE;
      S_ERR:    if (start) state_d = S_LEN_LO; else state_d = S_ERR;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM output decode; done waits one cycle after the last word's write strobe.
  always_comb begin
    ready_d    = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                 (state_d == S_DATA)   || (state_d == S_CHK);
    done_d     = (state_d == S_DONE) && (state_q != S_DATA);
    err_d      = (state_d == S_ERR);
    core_rst_d = !done_d;
  end

  // Registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q    <= 1'b0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ready_q    <= ready_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Length capture, word counter, write address and checksum accumulator.
  always_comb begin
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    wr_addr_d  = wr_addr_q;
    if (accept_s && state_q == S_LEN_LO)      len_d[7:0]  = byte_data;
    else if (accept_s && state_q == S_LEN_HI) len_d[15:8] = byte_data;
    else                                      len_d       = len_q;
    if (clr_s) begin
      word_cnt_d = 17'd0;
    end else if (word_done_s) begin
      wr_addr_d  = word_cnt_q[ADDR_W-1:0];
      word_cnt_d = word_cnt_q + 17'd1;
    end else begin
      word_cnt_d = word_cnt_q;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d = csum_q;
    if (clr_s)                                 csum_d = 8'd0;
    else if (accept_s && state_q == S_DATA)    csum_d = csum_step(csum_q, byte_data);
    else                                       csum_d = csum_q;
`endif
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q      <= 16'd0;
      word_cnt_q <= 17'd0;
      wr_addr_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= 8'd0;
`endif
    end else begin
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      wr_addr_q  <= wr_addr_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign byte_ready = ready_q;
  assign wr_addr    = wr_addr_q;
  assign core_rst   = core_rst_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed frames, monitor pops expected writes.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst, start, byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, wr_en, core_rst, done, err;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          n_wr = 0;
  logic [41:0] exp_q[$];
  int          wr_cyc[$];
  logic [41:0] e;
  logic [31:0] img [0:1];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imem_loader #(.DEPTH(1024), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .core_rst(core_rst), .done(done), .err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && wr_en) begin
      n_wr++;
      wr_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0h data %0h, expected no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e[41:32]));
        chk("wr_data", wr_data, e[31:0]);
      end
      chk("wr_en_with_done", 32'(done), 32'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    for (int i = 0; i < gap; i++) begin
      byte_valid = 1'b0;
      @(posedge clk); #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    guard      = 0;
    while (!byte_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!byte_ready) begin
      checks++;
      errors++;
      $display("FAIL byte_ready_timeout: ready 0, expected 1");
    end else begin
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
  endtask

  task automatic send_frame(input int n, input int gap, input bit bad_csum);
    logic [7:0]  cs;
    logic [7:0]  b;
    logic [15:0] len;
    cs  = 8'd0;
    len = 16'(n);
    send_byte(len[7:0], gap);
    send_byte(len[15:8], gap);
    for (int i = 0; i < n; i++) begin
      for (int l = 0; l < 4; l++) begin
        b  = img[i][8*l +: 8];
        cs = cs ^ b;
        if (l == 3) exp_q.push_back({10'(i), img[i]});
        send_byte(b, gap);
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(bad_csum ? 8'h00 : cs, gap);
`else
    if (bad_csum) cs = 8'h00;
`endif
  endtask

  task automatic check_done(input string name);
`ifndef IMEM_LOADER_CHECKSUM_EN
    chk({name, "_wr_en_last"}, 32'(wr_en), 32'd1);
    chk({name, "_done_early"}, 32'(done), 32'd0);
    @(posedge clk); #1;
`endif
    chk({name, "_done"}, 32'(done), 32'd1);
    chk({name, "_core_rst"}, 32'(core_rst), 32'd0);
    chk({name, "_err"}, 32'(err), 32'd0);
    chk({name, "_byte_ready"}, 32'(byte_ready), 32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    img[0] = 32'h00c50493;
    img[1] = 32'h003202b3;
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_byte_ready", 32'(byte_ready), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Basic load with no bubbles.
    pulse_start();
    chk("basic_ready", 32'(byte_ready), 32'd1);
    send_frame(2, 0, 1'b0);
    check_done("basic");
    chk("basic_writes", 32'(n_wr), 32'd2);
    if (wr_cyc.size() >= 2) chk("basic_spacing", 32'(wr_cyc[1] - wr_cyc[0]), 32'd4);

    // Restart from DONE, then reload with alternate-cycle gaps.
    pulse_start();
    chk("restart_core_rst", 32'(core_rst), 32'd1);
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_ready", 32'(byte_ready), 32'd1);
    send_frame(2, 1, 1'b0);
    check_done("gaps");
    chk("gaps_writes", 32'(n_wr), 32'd4);

    // Empty image.
    pulse_start();
    send_frame(0, 0, 1'b0);
    chk("n0_done", 32'(done), 32'd1);
    chk("n0_core_rst", 32'(core_rst), 32'd0);
    repeat (3) @(posedge clk);
    #1 chk("n0_writes", 32'(n_wr), 32'd4);

    // Oversized image: 1025 words.
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    chk("big_err", 32'(err), 32'd1);
    chk("big_core_rst", 32'(core_rst), 32'd1);
    chk("big_ready", 32'(byte_ready), 32'd0);
    chk("big_done", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    #1 chk("big_writes", 32'(n_wr), 32'd4);

    // Reset after two bytes of word 1: only word 0 may be written.
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    exp_q.push_back({10'd0, img[0]});
    send_byte(8'h93, 0); send_byte(8'h04, 0); send_byte(8'hc5, 0); send_byte(8'h00, 0);
    send_byte(8'hb3, 0); send_byte(8'h02, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_core_rst", 32'(core_rst), 32'd1);
    chk("midrst_ready", 32'(byte_ready), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    repeat (8) @(posedge clk);
    #1 chk("midrst_writes", 32'(n_wr), 32'd5);
    pulse_start();
    send_frame(2, 0, 1'b0);
    check_done("reload");
    chk("reload_writes", 32'(n_wr), 32'd7);

`ifdef IMEM_LOADER_CHECKSUM_EN
    pulse_start();
    send_frame(2, 0, 1'b0);
    chk("csum_ok_done", 32'(done), 32'd1);
    pulse_start();
    send_frame(2, 0, 1'b1);
    chk("csum_bad_err", 32'(err), 32'd1);
    chk("csum_bad_core_rst", 32'(core_rst), 32'd1);
    chk("csum_bad_done", 32'(done), 32'd0);
`endif

    repeat (2) @(posedge clk);
    #1 chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
